// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequenced 4x4 vedic multiplier controller.
// Each step selects a pair of 2-bit operand slices and gives the left shift for its partial product.
package vedic_pkg;

   localparam int OPND_W  = 4;
   localparam int PROD_W  = 8;
   localparam int STEP_W  = 2;
   localparam int SHIFT_W = 3;

   localparam logic [SHIFT_W-1:0] SHIFT_S0 = 3'd0;
   localparam logic [SHIFT_W-1:0] SHIFT_S1 = 3'd2;
   localparam logic [SHIFT_W-1:0] SHIFT_S2 = 3'd2;
   localparam logic [SHIFT_W-1:0] SHIFT_S3 = 3'd4;
   localparam logic [STEP_W-1:0]  LAST_STEP = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic a1;
      logic a0;
      logic b1;
      logic b0;
   } core_ops_t;

   function automatic logic [SHIFT_W-1:0] step_shift(input logic [STEP_W-1:0] step);
      case (step)
         2'd0:    step_shift = SHIFT_S0;
         2'd1:    step_shift = SHIFT_S1;
         2'd2:    step_shift = SHIFT_S2;
         2'd3:    step_shift = SHIFT_S3;
         default: step_shift = SHIFT_S0;
      endcase
   endfunction

   // step[0] picks the high slice of a, step[1] the high slice of b.
   function automatic core_ops_t step_ops(input logic [STEP_W-1:0] step,
                                          input logic [OPND_W-1:0] a,
                                          input logic [OPND_W-1:0] b);
      logic [1:0] a_sel;
      logic [1:0] b_sel;
      a_sel    = step[0] ? a[3:2] : a[1:0];
      b_sel    = step[1] ? b[3:2] : b[1:0];
      step_ops = {a_sel, b_sel};
   endfunction

endpackage

// File: rtl/vedic_err_counter.sv
// Saturating mismatch counter; a clear on the same edge as an increment wins.
module vedic_err_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/vedic4x4_seq_ctrl.sv
// 4x4 unsigned multiply built from four passes through an external 2x2 core,
// with a reference-product check that counts mismatching results.
module vedic4x4_seq_ctrl
   import vedic_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter bit CHECK_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] in_a,
   input  logic [OPND_W-1:0] in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_p,
   output logic              out_err,
   output logic              core_a0,
   output logic              core_a1,
   output logic              core_b0,
   output logic              core_b1,
   input  logic [3:0]        core_q,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [STEP_W-1:0]   op_step_q, op_step_d;
   logic                op_vld_q, op_vld_d;
   logic [OPND_W-1:0]   a_q, a_d;
   logic [OPND_W-1:0]   b_q, b_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [PROD_W-1:0]   out_p_q, out_p_d;
   logic                out_err_q, out_err_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   core_ops_t           ops_q, ops_d;

   logic [PROD_W-1:0]   partial_s;
   logic [PROD_W-1:0]   acc_sum_s;
   logic [PROD_W-1:0]   ref_s;
   logic                mismatch_s;
   logic                cnt_inc_s;

   // Core operands are registered, so the core result belongs to op_step_q, one cycle behind step_q.
   assign partial_s  = {{(PROD_W-4){1'b0}}, core_q} << step_shift(op_step_q);
   assign acc_sum_s  = acc_q + partial_s;
   assign ref_s      = {{(PROD_W-OPND_W){1'b0}}, a_q} * {{(PROD_W-OPND_W){1'b0}}, b_q};
   assign mismatch_s = CHECK_EN ? (acc_sum_s != ref_s) : 1'b0;

   // Next-state, datapath and output decode.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      op_step_d = op_step_q;
      op_vld_d  = op_vld_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      out_p_d   = out_p_q;
      out_err_d = out_err_q;
      ops_d     = '0;
      cnt_inc_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d       = in_a;
               b_d       = in_b;
               acc_d     = '0;
               step_d    = '0;
               op_step_d = '0;
               op_vld_d  = 1'b0;
               out_err_d = 1'b0;
               state_d   = ST_MUL;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (op_vld_q) begin
               acc_d = acc_sum_s;
            end else begin
               acc_d = acc_q;
            end
            if (op_vld_q && (op_step_q == LAST_STEP)) begin
               op_vld_d  = 1'b0;
               out_p_d   = acc_sum_s;
               out_err_d = mismatch_s;
               cnt_inc_s = mismatch_s;
               state_d   = ST_DONE;
            end else begin
               ops_d     = step_ops(step_q, a_q, b_q);
               op_step_d = step_q;
               op_vld_d  = 1'b1;
               step_d    = step_q + 2'd1;
               state_d   = ST_MUL;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         op_step_q   <= '0;
         op_vld_q    <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         out_p_q     <= '0;
         out_err_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         ops_q       <= '0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         op_step_q   <= op_step_d;
         op_vld_q    <= op_vld_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         out_p_q     <= out_p_d;
         out_err_q   <= out_err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         ops_q       <= ops_d;
      end
   end

   vedic_err_counter #(
      .CNT_W (CNT_W)
   ) u_err_counter (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (cnt_inc_s),
      .clr_i (clr_cnt),
      .cnt_o (err_cnt)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_p     = out_p_q;
   assign out_err   = out_err_q;
   assign core_a0   = ops_q.a0;
   assign core_a1   = ops_q.a1;
   assign core_b0   = ops_q.b0;
   assign core_b1   = ops_q.b1;

endmodule

// File: tb/tb_vedic4x4_seq_ctrl.sv
// Scoreboard bench for vedic4x4_seq_ctrl with a 2x2 core model that can be switched to a trojaned variant.
module tb_vedic4x4_seq_ctrl;

   localparam int TB_CNT_W = 2;

   typedef struct {
      logic [7:0]          p;
      logic                err;
      logic [TB_CNT_W-1:0] cnt;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [3:0]          in_a;
   logic [3:0]          in_b;
   logic                out_valid;
   logic                out_ready;
   logic [7:0]          out_p;
   logic                out_err;
   logic                core_a0, core_a1, core_b0, core_b1;
   logic [3:0]          core_q;
   logic                clr_cnt;
   logic [TB_CNT_W-1:0] err_cnt;
   logic                troj;

   exp_t                sb[$];
   int                  n_checks = 0;
   int                  n_errors = 0;
   int                  cyc = 0;
   int                  acc_cyc = 0;
   logic [TB_CNT_W-1:0] exp_cnt = '0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Trojan payload clears the weight-4 product bit whenever both high operand bits are set.
   function automatic logic [3:0] core_model(input logic a1, input logic a0,
                                             input logic b1, input logic b0, input logic trj);
      logic [3:0] q;
      q = {2'b00, a1, a0} * {2'b00, b1, b0};
      if (trj && a1 && b1) q[2] = 1'b0;
      return q;
   endfunction

   assign core_q = core_model(core_a1, core_a0, core_b1, core_b0, troj);

   function automatic logic [7:0] model_prod(input logic [3:0] a, input logic [3:0] b, input logic trj);
      logic [7:0] p;
      p = {4'd0, core_model(a[1], a[0], b[1], b[0], trj)};
      p = p + ({4'd0, core_model(a[3], a[2], b[1], b[0], trj)} << 2);
      p = p + ({4'd0, core_model(a[1], a[0], b[3], b[2], trj)} << 2);
      p = p + ({4'd0, core_model(a[3], a[2], b[3], b[2], trj)} << 4);
      return p;
   endfunction

   vedic4x4_seq_ctrl #(
      .CNT_W    (TB_CNT_W),
      .CHECK_EN (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_err   (out_err),
      .core_a0   (core_a0),
      .core_a1   (core_a1),
      .core_b0   (core_b0),
      .core_b1   (core_b1),
      .core_q    (core_q),
      .clr_cnt   (clr_cnt),
      .err_cnt   (err_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present a request, wait for acceptance and push the expected result.
   task automatic send(input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      int   n;
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 acc_cyc = cyc;
      e.p   = model_prod(a, b, troj);
      e.err = (e.p != ({4'd0, a} * {4'd0, b}));
      if (clr_cnt) exp_cnt = '0;
      else if (e.err && exp_cnt != {TB_CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      e.cnt = exp_cnt;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for out_valid, pop the scoreboard and compare; completes the handshake when out_ready is high.
   task automatic receive();
      exp_t e;
      int   n;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_eq("out_valid", 32'(out_valid), 32'd1);
      if (sb.size() == 0) begin
         check_eq("sb_underflow", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_eq("latency", 32'(cyc - acc_cyc), 32'd5);
         check_eq("out_p", 32'(out_p), 32'(e.p));
         check_eq("out_err", 32'(out_err), 32'(e.err));
         check_eq("err_cnt", 32'(err_cnt), 32'(e.cnt));
      end
      if (out_ready) @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 4'd0;
      in_b      = 4'd0;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;
      troj      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_p", 32'(out_p), 32'd0);
      check_eq("rst_out_err", 32'(out_err), 32'd0);
      check_eq("rst_core_ops", 32'({core_a1, core_a0, core_b1, core_b0}), 32'd0);
      check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;

      send(4'hF, 4'hF);
      receive();

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            send(4'(a), 4'(b));
            receive();
         end
      end

      // Trojaned core: A*A mismatches every time; counter saturates at 3.
      troj = 1'b1;
      repeat (5) begin
         send(4'hA, 4'hA);
         receive();
      end
      clr_cnt = 1'b1;
      send(4'hA, 4'hA);
      receive();
      clr_cnt = 1'b0;
      send(4'hA, 4'hA);
      receive();

      // Back-pressure: result held and a waiting request refused until the handshake.
      troj      = 1'b0;
      out_ready = 1'b0;
      send(4'd3, 4'd5);
      receive();
      in_valid = 1'b1;
      in_a     = 4'd1;
      in_b     = 4'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("hold_out_p", 32'(out_p), 32'h0F);
         check_eq("hold_out_valid", 32'(out_valid), 32'd1);
         check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      send(4'd1, 4'd1);
      receive();

      // Reset in the middle of a transaction aborts it and clears the counter.
      troj = 1'b1;
      send(4'd7, 4'd9);
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = '0;
      check_eq("abort_in_ready", 32'(in_ready), 32'd1);
      check_eq("abort_out_valid", 32'(out_valid), 32'd0);
      check_eq("abort_core_ops", 32'({core_a1, core_a0, core_b1, core_b0}), 32'd0);
      check_eq("abort_err_cnt", 32'(err_cnt), 32'd0);
      troj = 1'b0;
      send(4'd2, 4'd3);
      receive();
      check_eq("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
